// File: rtl/sync_fifo_param.sv
// Single-clock FIFO, DEPTH = 2**ADDR_WIDTH; define SYNC_FIFO_FWFT_EN for first-word-fall-through.
// Latency: a written word is readable the cycle after it is written; standard RD_DATA lags its read by one cycle.
// Backpressure: writes are dropped when FULL and reads refused when EMPTY, each flagged by a one-cycle OVERFLOW/UNDERFLOW pulse.
module sync_fifo_param #(
  parameter int DATA_WIDTH        = 18,
  parameter int ADDR_WIDTH        = 10,
  parameter int PROG_EMPTY_THRESH = 4,
  parameter int PROG_FULL_THRESH  = 1020
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [ADDR_WIDTH:0]   WORD_COUNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  PROG_EMPTY,
  output logic                  PROG_FULL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PE_W    = (ADDR_WIDTH+1)'(PROG_EMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] PF_W    = (ADDR_WIDTH+1)'(PROG_FULL_THRESH);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 72) begin : g_bad_data_width
    $error("sync_fifo_param: DATA_WIDTH out of range 1..72");
  end
  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 12) begin : g_bad_addr_width
    $error("sync_fifo_param: ADDR_WIDTH out of range 2..12");
  end
  if (PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH > DEPTH-1) begin : g_bad_pe_thresh
    $error("sync_fifo_param: PROG_EMPTY_THRESH out of range 1..DEPTH-1");
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH-1) begin : g_bad_pf_thresh
    $error("sync_fifo_param: PROG_FULL_THRESH out of range 1..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;

  assign EMPTY        = (count_q == '0);
  assign FULL         = (count_q == DEPTH_W);
  assign ALMOST_EMPTY = (count_q == (ADDR_WIDTH+1)'(1));
  assign ALMOST_FULL  = (count_q == DEPTH_W - (ADDR_WIDTH+1)'(1));
  assign PROG_EMPTY   = (count_q <= PE_W);
  assign PROG_FULL    = (count_q >= PF_W);
  assign WORD_COUNT   = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

  assign wr_acc = WR_EN & ~FULL;
  assign rd_acc = RD_EN & ~EMPTY;

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    // Errors are flagged on the request alone, even when the other side is accepted.
    ovf_d = WR_EN & FULL;
    udf_d = RD_EN & EMPTY;
  end

  // Storage is never cleared; reset only rewinds the pointers and count.
  always_ff @(posedge CLK) begin
    if (!RESET && wr_acc) begin
      mem_q[wr_ptr_q] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign RD_DATA = mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign RD_DATA = rd_data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed and scoreboarded bench for sync_fifo_param: default-size instance plus a 16-deep instance.
module tb_sync_fifo_param;

  logic        clk;
  logic        rst, wr_en, rd_en;
  logic [17:0] wr_data, rd_data;
  logic [10:0] word_count;
  logic        empty, full, ae, af, pe, pf, ovf, udf;

  logic        s_rst, s_wr, s_rd;
  logic [7:0]  s_wd, s_rdd;
  logic [4:0]  s_cnt;
  logic        s_empty, s_full, s_ae, s_af, s_pe, s_pf, s_ovf, s_udf;

  int checks = 0;
  int failures = 0;

  sync_fifo_param dut (
    .CLK(clk), .RESET(rst), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
    .RD_DATA(rd_data), .WORD_COUNT(word_count), .EMPTY(empty), .FULL(full),
    .ALMOST_EMPTY(ae), .ALMOST_FULL(af), .PROG_EMPTY(pe), .PROG_FULL(pf),
    .OVERFLOW(ovf), .UNDERFLOW(udf)
  );

  sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PROG_EMPTY_THRESH(2), .PROG_FULL_THRESH(14)) dut_s (
    .CLK(clk), .RESET(s_rst), .WR_EN(s_wr), .WR_DATA(s_wd), .RD_EN(s_rd),
    .RD_DATA(s_rdd), .WORD_COUNT(s_cnt), .EMPTY(s_empty), .FULL(s_full),
    .ALMOST_EMPTY(s_ae), .ALMOST_FULL(s_af), .PROG_EMPTY(s_pe), .PROG_FULL(s_pf),
    .OVERFLOW(s_ovf), .UNDERFLOW(s_udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [17:0] d, input logic r);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin : main
    logic [7:0] q[$];
    logic [7:0] exp_rd;
    int cnt;
    logic acc_w, acc_r, e_ovf, e_udf;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    s_rst = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_wd = '0;
    cyc(0, 0, 0); cyc(0, 0, 0);
    rst = 1'b0;

    check("rst_count", 32'(word_count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_ae", 32'(ae), 0);
    check("rst_pe", 32'(pe), 1);
    check("rst_full", 32'(full), 0);
    check("rst_af", 32'(af), 0);
    check("rst_pf", 32'(pf), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_udf", 32'(udf), 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_rd_data", 32'(rd_data), 0);
`endif

    for (int i = 1; i <= 4; i++) begin
      cyc(1, 18'(i), 0);
      if (i == 1) check("ae_at_1", 32'(ae), 1);
    end
    check("w4_count", 32'(word_count), 4);
    check("w4_pe", 32'(pe), 1);
    check("w4_empty", 32'(empty), 0);
    check("w4_ae", 32'(ae), 0);

    for (int i = 1; i <= 4; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("r4_data", 32'(rd_data), 32'(i));
      cyc(0, 0, 1);
`else
      cyc(0, 0, 1);
      check("r4_data", 32'(rd_data), 32'(i));
`endif
    end
    check("r4_empty", 32'(empty), 1);

    for (int k = 0; k < 1024; k++) begin
      cyc(1, 18'('h1000 + k), 0);
      if (k + 1 == 1019) check("pf_at_1019", 32'(pf), 0);
      if (k + 1 == 1020) check("pf_at_1020", 32'(pf), 1);
      if (k + 1 == 1023) begin
        check("af_at_1023", 32'(af), 1);
        check("full_at_1023", 32'(full), 0);
      end
    end
    check("fill_count", 32'(word_count), 1024);
    check("fill_full", 32'(full), 1);
    check("fill_af", 32'(af), 0);
    check("fill_pf", 32'(pf), 1);

    cyc(1, 18'h3FFFF, 0);
    check("ovf_pulse", 32'(ovf), 1);
    check("ovf_count", 32'(word_count), 1024);
    cyc(0, 0, 0);
    check("ovf_clear", 32'(ovf), 0);

    cyc(1, 18'h3FFFE, 1);
    check("fullrw_ovf", 32'(ovf), 1);
    check("fullrw_count", 32'(word_count), 1023);
    check("fullrw_af", 32'(af), 1);
`ifdef SYNC_FIFO_FWFT_EN
    check("fullrw_data", 32'(rd_data), 32'h1001);
`else
    check("fullrw_data", 32'(rd_data), 32'h1000);
`endif

    for (int k = 1; k < 1024; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("drain_data", 32'(rd_data), 32'('h1000 + k));
      cyc(0, 0, 1);
`else
      cyc(0, 0, 1);
      check("drain_data", 32'(rd_data), 32'('h1000 + k));
`endif
    end
    check("drain_empty", 32'(empty), 1);

    cyc(1, 18'h2A, 1);
    check("udf_pulse", 32'(udf), 1);
    check("udf_count", 32'(word_count), 1);
`ifdef SYNC_FIFO_FWFT_EN
    check("udf_fwft_data", 32'(rd_data), 32'h2A);
    cyc(0, 0, 1);
`else
    check("udf_data_hold", 32'(rd_data), 32'h13FF);
    cyc(0, 0, 1);
    check("udf_next_read", 32'(rd_data), 32'h2A);
`endif
    check("udf_clear", 32'(udf), 0);
    check("udf_drained", 32'(word_count), 0);

    cyc(1, 18'h155, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_fall", 32'(rd_data), 32'h155);
`else
    check("std_no_fall", 32'(rd_data), 32'h2A);
    cyc(0, 0, 1);
    check("std_read_155", 32'(rd_data), 32'h155);
`endif

    // Scoreboarded random traffic on the 16-deep instance, alternating write/read-heavy phases.
    @(posedge clk); #1;
    s_rst = 1'b0;
    exp_rd = '0;
    for (int op = 0; op < 3000; op++) begin
      if (op == 1500) begin
        s_rst = 1'b1; s_wr = 1'b1; s_rd = 1'b1; s_wd = 8'hEE;
        @(posedge clk); #1;
        s_rst = 1'b0;
        q.delete();
        exp_rd = '0;
        check("mid_rst_count", 32'(s_cnt), 0);
        check("mid_rst_empty", 32'(s_empty), 1);
        check("mid_rst_ovf", 32'(s_ovf), 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("mid_rst_data", 32'(s_rdd), 0);
`endif
        continue;
      end
      s_wr = ($urandom_range(0, 99) < ((((op / 100) % 2) == 0) ? 75 : 25));
      s_rd = ($urandom_range(0, 99) < ((((op / 100) % 2) == 0) ? 25 : 75));
      s_wd = 8'($urandom);
      cnt   = q.size();
      acc_w = s_wr && (cnt != 16);
      acc_r = s_rd && (cnt != 0);
      e_ovf = s_wr && (cnt == 16);
      e_udf = s_rd && (cnt == 0);
      @(posedge clk); #1;
      if (acc_r) exp_rd = q.pop_front();
      if (acc_w) q.push_back(s_wd);
      cnt = q.size();
      check("rnd_count", 32'(s_cnt), 32'(cnt));
      check("rnd_empty", 32'(s_empty), 32'(cnt == 0));
      check("rnd_full", 32'(s_full), 32'(cnt == 16));
      check("rnd_ae", 32'(s_ae), 32'(cnt == 1));
      check("rnd_af", 32'(s_af), 32'(cnt == 15));
      check("rnd_pe", 32'(s_pe), 32'(cnt <= 2));
      check("rnd_pf", 32'(s_pf), 32'(cnt >= 14));
      check("rnd_ovf", 32'(s_ovf), 32'(e_ovf));
      check("rnd_udf", 32'(s_udf), 32'(e_udf));
`ifdef SYNC_FIFO_FWFT_EN
      if (cnt != 0) check("rnd_data", 32'(s_rdd), 32'(q[0]));
`else
      check("rnd_data", 32'(s_rdd), 32'(exp_rd));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
